morra_giocatore_auto: RTL and testbench
=======================================

Name: morra_giocatore_auto

Overview:
Automatic two-player stimulus engine for the Morra Cinese referee. It is the move-producing end of the referee's interface: it drives primo/secondo/inizia and consumes manche/partita. It generates legal pseudo-random move pairs, obeys the no-repeat-winning-move rule, keeps score and reports the match result. It is used for self-play demos and as a bench driver for the referee.

Parameters:
LFSR_SEED, 16'hACE1, initial LFSR value; 0 is replaced by 16'h0001.
WATCHDOG, 32, maximum PLAY cycles before a match is aborted.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
avvia  in  1  start-match request, sampled in IDLE/DONE
num_manche_cfg  in  4  match config placed on {primo,secondo} in the inizia cycle; referee max manche = cfg+4
manche  in  2  referee manche result for the current move pair: 00 invalid, 01 P1, 10 P2, 11 draw
partita  in  2  referee match result: 00 running, 01 P1, 10 P2, 11 draw
primo  out  2  player-1 move: 01 sasso, 10 carta, 11 forbice, 00 none
secondo  out  2  player-2 move, same encoding
inizia  out  1  match-start strobe to the referee
occupato  out  1  high in CONFIG and PLAY
fine  out  1  one-cycle pulse when a match ends
esito  out  2  latched final partita value
errore  out  1  watchdog abort flag, held until next start
vinte_p1  out  5  manches won by P1, saturating
vinte_p2  out  5  manches won by P2, saturating
giocate  out  5  valid manches played (01/10/11), saturating

Behaviour:
- Decided interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: primo=secondo=00, inizia=0, occupato=0, fine=0, esito=00, errore=0, all counters 0, LFSR=LFSR_SEED, restriction cleared, state IDLE. `rst` mid-match reaches reset state at the next edge; inizia is not asserted.
- States: IDLE, CONFIG, PLAY, DONE. All outputs are registered.
- IDLE/DONE: primo=secondo=00, inizia=0.
  - avvia=1 latches num_manche_cfg.
  - It clears counters, esito, errore and the restriction.
  - Next state is CONFIG.
- CONFIG (exactly 1 cycle): inizia=1, {primo,secondo}=latched cfg. Next state is PLAY.
- PLAY: a new move pair is presented every cycle. Outputs are registered, so the referee's combinational manche/partita refer to the currently driven pair; both are sampled at the same edge.
- Move generation:
  - LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifted left once per PLAY cycle.
  - Raw P1 move = lfsr[1:0], raw P2 move = lfsr[3:2]; a raw 00 maps to 01.
- Legality: if the last decisive manche was won by player X with move M, X's candidate equal to M is rotated 01->10->11->01. The other player is unrestricted. A draw (11) clears the restriction; invalid (00) leaves it unchanged.
- Sampling at each PLAY edge:
  - manche=01: vinte_p1++, giocate++, restriction={P1, primo}.
  - manche=10: vinte_p2++, giocate++, restriction={P2, secondo}.
  - manche=11: giocate++, restriction cleared.
  - manche=00: no update.
  - Counters saturate at 31.
- End of match:
  - partita!=00 in PLAY: esito=partita, fine=1 for the following cycle, state DONE. The manche sampled at the same edge is still counted.
  - WATCHDOG PLAY cycles with partita=00: errore=1, esito=00, fine pulse, state DONE.
- avvia in CONFIG/PLAY is ignored. avvia in the same cycle as a fine pulse (DONE) starts a new match.

Test Plan:
- Reset then idle 5 cycles -> primo=secondo=00, inizia=0, occupato=0, fine=0, counters 0.
- avvia=1, num_manche_cfg=4'b0110 -> next cycle inizia=1, primo=01, secondo=10, occupato=1; following cycle inizia=0, primo,secondo ∈ {01,10,11}.
- Mock referee returns manche=01 while primo=10 -> vinte_p1=1, giocate=1; on every later cycle until a draw, primo!=10. Then return manche=11 -> restriction lifted, giocate=2.
- Mock returns manche=10 for 3 cycles, then partita=10 -> vinte_p2=3, esito=10, fine high exactly 1 cycle, occupato=0, outputs 00 and held in DONE.
- Mock ties manche=00, partita=00 -> after 32 PLAY cycles errore=1, esito=00, fine pulse, giocate=0; subsequent avvia clears errore.
- rst=1 during PLAY with vinte_p1=2 -> next cycle all outputs at reset values, state IDLE; avvia restarts from CONFIG with LFSR reloaded to LFSR_SEED (identical first move pair to the first run).

Source files
------------

// File: rtl/morra_giocatore_auto.sv
// Self-playing Morra Cinese opponent pair: drives legal LFSR move pairs into the referee and scores its verdicts.
// Latency: one registered move pair per PLAY cycle, verdicts sampled on the same edge; no backpressure, a watchdog aborts a stalled match.
module morra_giocatore_auto #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          WATCHDOG  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       avvia,
    input  logic [3:0] num_manche_cfg,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic [1:0] primo,
    output logic [1:0] secondo,
    output logic       inizia,
    output logic       occupato,
    output logic       fine,
    output logic [1:0] esito,
    output logic       errore,
    output logic [4:0] vinte_p1,
    output logic [4:0] vinte_p2,
    output logic [4:0] giocate
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONFIG = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          WDW  = $clog2(WATCHDOG + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG - 1);

    logic [1:0]     state;
    logic [15:0]    lfsr;
    logic [WDW-1:0] wd_cnt;
    logic           rs_vld, rs_p2;
    logic [1:0]     rs_mov;

    logic           rs_vld_n, rs_p2_n;
    logic [1:0]     rs_mov_n;
    logic [15:0]    lfsr_nxt;
    logic [1:0]     raw1, raw2, cand1, cand2;

    function automatic logic [1:0] rot(input logic [1:0] m);
        return (m == 2'b11) ? 2'b01 : m + 2'b01;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // The verdict sampled this edge must already constrain the pair registered on it.
    always_comb begin
        rs_vld_n = rs_vld;
        rs_p2_n  = rs_p2;
        rs_mov_n = rs_mov;
        if (state == S_PLAY) begin
            case (manche)
                2'b01:   begin rs_vld_n = 1'b1; rs_p2_n = 1'b0; rs_mov_n = primo;   end
                2'b10:   begin rs_vld_n = 1'b1; rs_p2_n = 1'b1; rs_mov_n = secondo; end
                2'b11:   rs_vld_n = 1'b0;
                default: ;
            endcase
        end
        raw1  = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
        raw2  = (lfsr[3:2] == 2'b00) ? 2'b01 : lfsr[3:2];
        cand1 = (rs_vld_n && !rs_p2_n && raw1 == rs_mov_n) ? rot(raw1) : raw1;
        cand2 = (rs_vld_n &&  rs_p2_n && raw2 == rs_mov_n) ? rot(raw2) : raw2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lfsr     <= SEED;
            wd_cnt   <= '0;
            rs_vld   <= 1'b0;
            rs_p2    <= 1'b0;
            rs_mov   <= 2'b00;
            primo    <= 2'b00;
            secondo  <= 2'b00;
            inizia   <= 1'b0;
            occupato <= 1'b0;
            fine     <= 1'b0;
            esito    <= 2'b00;
            errore   <= 1'b0;
            vinte_p1 <= '0;
            vinte_p2 <= '0;
            giocate  <= '0;
        end else begin
            fine   <= 1'b0;
            inizia <= 1'b0;
            case (state)
                S_CONFIG: begin
                    primo   <= cand1;
                    secondo <= cand2;
                    lfsr    <= lfsr_nxt;
                    wd_cnt  <= '0;
                    state   <= S_PLAY;
                end
                S_PLAY: begin
                    rs_vld <= rs_vld_n;
                    rs_p2  <= rs_p2_n;
                    rs_mov <= rs_mov_n;
                    if (manche == 2'b01) vinte_p1 <= sat_inc(vinte_p1);
                    if (manche == 2'b10) vinte_p2 <= sat_inc(vinte_p2);
                    if (manche != 2'b00) giocate  <= sat_inc(giocate);
                    if (partita != 2'b00 || wd_cnt == WD_LAST) begin
                        esito    <= partita;
                        errore   <= (partita == 2'b00);
                        fine     <= 1'b1;
                        occupato <= 1'b0;
                        primo    <= 2'b00;
                        secondo  <= 2'b00;
                        state    <= S_DONE;
                    end else begin
                        primo   <= cand1;
                        secondo <= cand2;
                        lfsr    <= lfsr_nxt;
                        wd_cnt  <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    primo   <= 2'b00;
                    secondo <= 2'b00;
                    if (avvia) begin
                        primo    <= num_manche_cfg[3:2];
                        secondo  <= num_manche_cfg[1:0];
                        inizia   <= 1'b1;
                        occupato <= 1'b1;
                        vinte_p1 <= '0;
                        vinte_p2 <= '0;
                        giocate  <= '0;
                        esito    <= 2'b00;
                        errore   <= 1'b0;
                        rs_vld   <= 1'b0;
                        state    <= S_CONFIG;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_giocatore_auto.sv
// Directed bench for morra_giocatore_auto: a mock referee drives verdicts, a scoreboard checks start strobes and end-of-match reports.
module tb_morra_giocatore_auto;

    logic       clk = 1'b0;
    logic       rst, avvia;
    logic [3:0] num_manche_cfg;
    logic [1:0] manche, partita;
    logic [1:0] primo, secondo, esito;
    logic       inizia, occupato, fine, errore;
    logic [4:0] vinte_p1, vinte_p2, giocate;

    morra_giocatore_auto dut (
        .clk(clk), .rst(rst), .avvia(avvia), .num_manche_cfg(num_manche_cfg),
        .manche(manche), .partita(partita), .primo(primo), .secondo(secondo),
        .inizia(inizia), .occupato(occupato), .fine(fine), .esito(esito),
        .errore(errore), .vinte_p1(vinte_p1), .vinte_p2(vinte_p2), .giocate(giocate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] p1;
        logic [1:0] p2;
    } ini_t;

    typedef struct {
        logic [1:0] esito;
        logic       errore;
        logic [4:0] v1;
        logic [4:0] v2;
        logic [4:0] g;
    } fin_t;

    ini_t ini_q[$];
    fin_t fin_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every start strobe and every end pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (inizia) begin
                if (ini_q.size() == 0) begin
                    check("unexpected_inizia", 32'(inizia), 32'd0);
                end else begin
                    ini_t e;
                    e = ini_q.pop_front();
                    check("cfg_primo", 32'(primo), 32'(e.p1));
                    check("cfg_secondo", 32'(secondo), 32'(e.p2));
                    check("cfg_occupato", 32'(occupato), 32'd1);
                end
            end
            if (fine) begin
                if (fin_q.size() == 0) begin
                    check("unexpected_fine", 32'(fine), 32'd0);
                end else begin
                    fin_t f;
                    f = fin_q.pop_front();
                    check("end_esito", 32'(esito), 32'(f.esito));
                    check("end_errore", 32'(errore), 32'(f.errore));
                    check("end_vinte_p1", 32'(vinte_p1), 32'(f.v1));
                    check("end_vinte_p2", 32'(vinte_p2), 32'(f.v2));
                    check("end_giocate", 32'(giocate), 32'(f.g));
                    check("end_occupato", 32'(occupato), 32'd0);
                    check("end_moves", 32'({primo, secondo}), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    logic [1:0] first_p1, first_p2;
    int         found, play_cyc;

    initial begin
        rst = 1'b1; avvia = 1'b0; num_manche_cfg = 4'b0000; manche = 2'b00; partita = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_moves", 32'({primo, secondo}), 32'd0);
        check("rst_strobes", 32'({inizia, occupato, fine, errore}), 32'd0);
        check("rst_esito", 32'(esito), 32'd0);
        check("rst_counters", 32'({vinte_p1, vinte_p2, giocate}), 32'd0);

        // Match 1: restriction, draw, P2 wins
        ini_q.push_back('{p1: 2'b01, p2: 2'b10});
        num_manche_cfg = 4'b0110; avvia = 1'b1;
        @(negedge clk); avvia = 1'b0;
        @(negedge clk);
        check("play_inizia_low", 32'(inizia), 32'd0);
        check("play_p1_legal", 32'(primo != 2'b00), 32'd1);
        check("play_p2_legal", 32'(secondo != 2'b00), 32'd1);
        first_p1 = primo; first_p2 = secondo;

        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            if (primo == 2'b10) begin
                manche = 2'b01; found = 1;
            end else begin
                manche = 2'b00;
            end
            @(negedge clk);
        end
        manche = 2'b00;
        check("p1_carta_seen", 32'(found), 32'd1);
        check("win_vinte_p1", 32'(vinte_p1), 32'd1);
        check("win_giocate", 32'(giocate), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("restricted_p1", 32'(primo == 2'b10), 32'd0);
            check("restricted_p1_legal", 32'(primo != 2'b00), 32'd1);
            @(negedge clk);
        end
        manche = 2'b11;
        @(negedge clk); manche = 2'b00;
        check("draw_giocate", 32'(giocate), 32'd2);

        manche = 2'b10;
        repeat (3) @(negedge clk);
        manche = 2'b00; partita = 2'b10;
        fin_q.push_back('{esito: 2'b10, errore: 1'b0, v1: 5'd1, v2: 5'd3, g: 5'd5});
        @(negedge clk); partita = 2'b00;
        check("fine_seen", 32'(fine), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("done_fine_low", 32'(fine), 32'd0);
            check("done_held", 32'({occupato, primo, secondo}), 32'd0);
            check("done_esito", 32'(esito), 32'd2);
        end

        // Match 2: referee never answers, watchdog aborts
        ini_q.push_back('{p1: 2'b01, p2: 2'b10});
        fin_q.push_back('{esito: 2'b00, errore: 1'b1, v1: 5'd0, v2: 5'd0, g: 5'd0});
        avvia = 1'b1;
        @(negedge clk); avvia = 1'b0;
        play_cyc = 0;
        for (int i = 0; i < 60; i++) begin
            if (fine) break;
            if (occupato && !inizia) play_cyc++;
            @(negedge clk);
        end
        check("watchdog_fine", 32'(fine), 32'd1);
        check("watchdog_len", 32'(play_cyc), 32'd32);
        @(negedge clk);
        check("errore_held", 32'(errore), 32'd1);

        // Match 3: restart clears error, then reset mid-play
        ini_q.push_back('{p1: 2'b01, p2: 2'b10});
        avvia = 1'b1;
        @(negedge clk); avvia = 1'b0;
        check("restart_errore", 32'(errore), 32'd0);
        @(negedge clk);
        manche = 2'b01;
        repeat (2) @(negedge clk);
        manche = 2'b00;
        check("pre_rst_vinte_p1", 32'(vinte_p1), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_moves", 32'({primo, secondo}), 32'd0);
        check("midrst_strobes", 32'({inizia, occupato, fine, errore}), 32'd0);
        check("midrst_counters", 32'({vinte_p1, vinte_p2, giocate}), 32'd0);
        rst = 1'b0;

        ini_q.push_back('{p1: 2'b01, p2: 2'b10});
        avvia = 1'b1;
        @(negedge clk); avvia = 1'b0;
        @(negedge clk);
        check("reseed_p1", 32'(primo), 32'(first_p1));
        check("reseed_p2", 32'(secondo), 32'(first_p2));
        check("sb_drained", 32'(ini_q.size() + fin_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
